// File: rtl/alu_result_packer.sv
// Packs one ALU result word and its flags into a header/result-byte frame on an 8-bit valid/ready link.
// Header valid the cycle after input accept; one byte per cycle while out_ready; optional checksum via ALU_PKT_CHECKSUM_EN.
module alu_result_packer #(
    parameter int RESULT_BYTES = 4,
    parameter int LSB_FIRST    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic [3:0]  in_flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        busy,
    output logic [3:0]  seq
);

`ifdef ALU_PKT_CHECKSUM_EN
    localparam bit HAS_CSUM = 1'b1;
`else
    localparam bit HAS_CSUM = 1'b0;
`endif

    localparam logic [1:0] LAST_IDX = 2'(RESULT_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
`ifdef ALU_PKT_CHECKSUM_EN
        , CSUM = 2'd3
`endif
    } state_t;

    state_t      state;
    logic [31:0] result_q;
    logic [1:0]  idx;
`ifdef ALU_PKT_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    // Byte k of the frame payload, honouring the configured byte order.
    function automatic logic [7:0] pick(input logic [31:0] word, input logic [1:0] k);
        logic [1:0] pos;
        pos = (LSB_FIRST != 0) ? k : LAST_IDX - k;
        return word[{pos, 3'b000} +: 8];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            result_q  <= '0;
            idx       <= '0;
            seq       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
`ifdef ALU_PKT_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        result_q  <= in_result;
                        seq       <= seq + 4'd1;
                        out_data  <= {in_flags, seq + 4'd1};
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= HDR;
`ifdef ALU_PKT_CHECKSUM_EN
                        csum      <= {in_flags, seq + 4'd1};
`endif
                    end
                end
                HDR: begin
                    if (out_ready) begin
                        state    <= DATA;
                        idx      <= 2'd0;
                        out_data <= pick(result_q, 2'd0);
                        out_last <= !HAS_CSUM && (LAST_IDX == 2'd0);
`ifdef ALU_PKT_CHECKSUM_EN
                        csum     <= csum ^ pick(result_q, 2'd0);
`endif
                    end
                end
                DATA: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
`ifdef ALU_PKT_CHECKSUM_EN
                            state    <= CSUM;
                            out_data <= csum;
                            out_last <= 1'b1;
`else
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
`endif
                        end else begin
                            idx      <= idx + 2'd1;
                            out_data <= pick(result_q, idx + 2'd1);
                            out_last <= !HAS_CSUM && ((idx + 2'd1) == LAST_IDX);
`ifdef ALU_PKT_CHECKSUM_EN
                            csum     <= csum ^ pick(result_q, idx + 2'd1);
`endif
                        end
                    end
                end
`ifdef ALU_PKT_CHECKSUM_EN
                CSUM: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_last  <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_packer.sv
// Scoreboard bench: a default-configured packer plus an MSB-first two-byte instance.
module tb_alu_result_packer;

`ifdef ALU_PKT_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [31:0] in_result;
    logic [3:0]  in_flags, seq;
    logic [7:0]  out_data;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b, busy_b;
    logic [31:0] in_result_b;
    logic [3:0]  in_flags_b, seq_b;
    logic [7:0]  out_data_b;

    alu_result_packer dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .seq(seq)
    );

    alu_result_packer #(.RESULT_BYTES(2), .LSB_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_result(in_result_b), .in_flags(in_flags_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_data(out_data_b), .out_last(out_last_b),
        .busy(busy_b), .seq(seq_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [8:0] q_a[$];
    logic [8:0] q_b[$];
    logic [3:0] seq_m = 4'd0;

    // Expected frame: {last, byte} entries.
    task automatic build(input logic [31:0] r, input logic [3:0] f, input logic [3:0] s,
                         input int nb, input bit lsb, output logic [8:0] fr[0:5], output int n);
        logic [7:0] cs, b;
        int pos;
        for (int i = 0; i < 6; i++) fr[i] = '0;
        cs = {f, s};
        fr[0] = {1'b0, f, s};
        for (int k = 0; k < nb; k++) begin
            pos = lsb ? k : nb - 1 - k;
            b = r[8*pos +: 8];
            cs = cs ^ b;
            fr[k+1] = {(!CS && k == nb - 1), b};
        end
        n = nb + 1;
        if (CS) begin
            fr[n] = {1'b1, cs};
            n++;
        end
    endtask

    task automatic send_a(input logic [31:0] r, input logic [3:0] f);
        logic [8:0] fr[0:5];
        int n;
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_result = r;
        in_flags  = f;
        seq_m = seq_m + 4'd1;
        build(r, f, seq_m, 4, 1'b1, fr, n);
        for (int i = 0; i < n; i++) q_a.push_back(fr[i]);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_result = $urandom;
        in_flags  = 4'($urandom);
    endtask

    task automatic drain_a();
        int w = 0;
        while (q_a.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("drain_a", q_a.size(), 0);
        @(negedge clk);
    endtask

    // out_ready driver: constant 1 or the 1,0,0,1,0,1 pattern.
    int rdy_mode = 0;
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    initial begin
        int pi = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) out_ready = 1'b1;
            else begin
                out_ready = pat[pi];
                pi = (pi + 1) % 6;
            end
        end
    end

    // Monitor for dut_a: ordering, stall stability, in_ready/busy and frame-end handoff.
    logic [8:0] held;
    bit stall_a = 0;
    bit chk_rdy = 0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            stall_a = 0;
            chk_rdy = 0;
        end else begin
            if (chk_rdy) begin
                chk("rdy_after_frame", {31'd0, in_ready}, 32'd1);
                chk_rdy = 0;
            end
            if (out_valid) begin
                chk("in_ready_mid_frame", {31'd0, in_ready}, 32'd0);
                chk("busy_mid_frame", {31'd0, busy}, 32'd1);
                if (stall_a) chk("stall_hold", {23'd0, out_last, out_data}, {23'd0, held});
                if (out_ready) begin
                    stall_a = 0;
                    if (q_a.size() == 0) chk("extra_byte", q_a.size(), 1);
                    else begin
                        e = q_a.pop_front();
                        chk("byte_a", {23'd0, out_last, out_data}, {23'd0, e});
                        if (e[8]) chk_rdy = 1;
                    end
                end else begin
                    stall_a = 1;
                    held = {out_last, out_data};
                end
            end else stall_a = 0;
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n && out_valid_b && out_ready_b) begin
            if (q_b.size() == 0) chk("extra_byte_b", q_b.size(), 1);
            else begin
                e = q_b.pop_front();
                chk("byte_b", {23'd0, out_last_b, out_data_b}, {23'd0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] fr[0:5];
        int n;
        int w;
        rst_n = 1'b0;
        in_valid = 1'b0; in_result = '0; in_flags = '0;
        in_valid_b = 1'b0; in_result_b = '0; in_flags_b = '0; out_ready_b = 1'b1;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_seq", {28'd0, seq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Default frame, then MSB-first 2-byte instance in parallel.
        send_a(32'h12345678, 4'b0000);
        @(negedge clk);
        in_valid_b = 1'b1; in_result_b = 32'hAABBCCDD; in_flags_b = 4'b1001;
        build(32'hAABBCCDD, 4'b1001, 4'd1, 2, 1'b0, fr, n);
        for (int i = 0; i < n; i++) q_b.push_back(fr[i]);
        @(posedge clk);
        #1;
        in_valid_b = 1'b0; in_result_b = 32'hFFFF0000;
        drain_a();
        w = 0;
        while (q_b.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain_b", q_b.size(), 0);
        chk("seq_b", {28'd0, seq_b}, 32'd1);
        chk("busy_b_idle", {31'd0, busy_b}, 32'd0);

        // Stalled output.
        rdy_mode = 1;
        send_a(32'h12345678, 4'b0000);
        drain_a();
        rdy_mode = 0;

        // Back-to-back frames covering the sequence wrap.
        for (int i = 0; i < 17; i++) send_a($urandom, 4'($urandom));
        drain_a();

        // Reset after the second data byte.
        send_a(32'hCAFEF00D, 4'h3);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_last", {31'd0, out_last}, 32'd0);
        chk("midrst_seq", {28'd0, seq}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        q_a.delete();
        seq_m = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        send_a(32'h0BADBEEF, 4'h5);
        drain_a();

        // Zero result frame (checksum case when enabled).
        send_a(32'h00000000, 4'b1000);
        drain_a();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
